// File: rtl/inst_wb_fetch_if.sv
// Instruction fetch responder: one Wishbone B4 classic read per fetch request, with stall/flush handling.
// Raises stallreq_o while a read is outstanding; a read with no ack is abandoned after TIMEOUT cycles.
module inst_wb_fetch_if #(
  parameter logic [31:0] NOP_INST = 32'h00000000,
  parameter int          TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic [31:0] pc_i,
  input  logic [5:0]  stall,
  input  logic        flush,
  output logic [31:0] inst_o,
  output logic        stallreq_o,
  output logic        timeout_o,
  output logic [31:0] wb_adr_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    BUSY       = 2'd1,
    WAIT_STALL = 2'd2
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        cyc_q, cyc_d;
  logic [31:0] adr_q, adr_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] buf_q, buf_d;
  logic        to_q, to_d;

  // Only stall[1] (IF/ID hold) matters to this stage.
  logic stall_unused;
  assign stall_unused = ^{stall[5:2], stall[0]};

  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    adr_d      = adr_q;
    cnt_d      = cnt_q;
    buf_d      = buf_q;
    to_d       = 1'b0;
    stallreq_o = 1'b0;
    inst_o     = NOP_INST;
    case (state_q)
      IDLE: begin
        if (ce_i && !flush) begin
          stallreq_o = 1'b1;
          adr_d      = pc_i;
          cyc_d      = 1'b1;
          cnt_d      = 8'd0;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        if (flush) begin
          cyc_d   = 1'b0;
          state_d = IDLE;
        end else if (wb_ack_i) begin
          cyc_d  = 1'b0;
          inst_o = wb_dat_i;
          if (stall[1]) begin
            buf_d   = wb_dat_i;
            state_d = WAIT_STALL;
          end else begin
            state_d = IDLE;
          end
        end else begin
          stallreq_o = 1'b1;
          if (cnt_q == TMO_LAST) begin
            cyc_d   = 1'b0;
            to_d    = 1'b1;
            buf_d   = NOP_INST;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      WAIT_STALL: begin
        inst_o = buf_q;
        if (flush || !stall[1]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cyc_q   <= 1'b0;
      adr_q   <= 32'd0;
      cnt_q   <= 8'd0;
      buf_q   <= NOP_INST;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      adr_q   <= adr_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      to_q    <= to_d;
    end
  end

  assign wb_cyc_o  = cyc_q;
  assign wb_stb_o  = cyc_q;
  assign wb_adr_o  = adr_q;
  assign wb_we_o   = 1'b0;
  assign wb_sel_o  = 4'b1111;
  assign timeout_o = to_q;

endmodule

// File: tb/tb_inst_wb_fetch_if.sv
// Directed table-driven bench for inst_wb_fetch_if; each row is one clock cycle of inputs
// and the outputs expected during that cycle (sampled mid-cycle, before the next rising edge).
module tb_inst_wb_fetch_if;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk;
  logic        rst;
  logic        ce_i;
  logic [31:0] pc_i;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] inst_o;
  logic        stallreq_o;
  logic        timeout_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;

  inst_wb_fetch_if #(.NOP_INST(NOP), .TIMEOUT(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .ce_i       (ce_i),
    .pc_i       (pc_i),
    .stall      (stall),
    .flush      (flush),
    .inst_o     (inst_o),
    .stallreq_o (stallreq_o),
    .timeout_o  (timeout_o),
    .wb_adr_o   (wb_adr_o),
    .wb_dat_i   (wb_dat_i),
    .wb_ack_i   (wb_ack_i),
    .wb_cyc_o   (wb_cyc_o),
    .wb_stb_o   (wb_stb_o),
    .wb_we_o    (wb_we_o),
    .wb_sel_o   (wb_sel_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        chk;
    logic        rst;
    logic        ce;
    logic [31:0] pc;
    logic        st1;
    logic        fl;
    logic        ack;
    logic [31:0] dat;
    logic [31:0] e_inst;
    logic        e_sreq;
    logic        e_cyc;
    logic [31:0] e_adr;
    logic        e_to;
  } vec_t;

  vec_t tbl[$];
  int   total = 0;
  int   bad   = 0;

  task automatic v(input logic chk, input logic r, input logic ce, input logic [31:0] pc,
                   input logic st1, input logic fl, input logic ack, input logic [31:0] dat,
                   input logic [31:0] e_inst, input logic e_sreq, input logic e_cyc,
                   input logic [31:0] e_adr, input logic e_to);
    vec_t e;
    e.chk = chk; e.rst = r; e.ce = ce; e.pc = pc; e.st1 = st1; e.fl = fl;
    e.ack = ack; e.dat = dat; e.e_inst = e_inst; e.e_sreq = e_sreq;
    e.e_cyc = e_cyc; e.e_adr = e_adr; e.e_to = e_to;
    tbl.push_back(e);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, got, exp);
    end
  endtask

  task automatic drive(input logic r, input logic ce, input logic [31:0] pc, input logic st1,
                       input logic fl, input logic ack, input logic [31:0] dat);
    rst = r; ce_i = ce; pc_i = pc; stall = {4'b0, st1, 1'b0};
    flush = fl; wb_ack_i = ack; wb_dat_i = dat;
  endtask

  task automatic check_outs(input int idx, input logic [31:0] e_inst, input logic e_sreq,
                            input logic e_cyc, input logic [31:0] e_adr, input logic e_to);
    check("inst_o", idx, inst_o, e_inst);
    check("stallreq_o", idx, {31'b0, stallreq_o}, {31'b0, e_sreq});
    check("wb_cyc_o", idx, {31'b0, wb_cyc_o}, {31'b0, e_cyc});
    check("wb_stb_o", idx, {31'b0, wb_stb_o}, {31'b0, e_cyc});
    check("wb_adr_o", idx, wb_adr_o, e_adr);
    check("timeout_o", idx, {31'b0, timeout_o}, {31'b0, e_to});
  endtask

  initial begin
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);

    //  chk rst ce pc            st1 fl ack dat            inst          sreq cyc adr           to
    // reset
    v(0, 1, 0, 32'h0,        0, 0, 0, 32'h0,        NOP,          0, 0, 32'h0,        0);
    v(1, 1, 0, 32'h0,        0, 0, 0, 32'h0,        NOP,          0, 0, 32'h0,        0);
    // basic fetch, ack on third wait-state cycle
    v(1, 0, 1, 32'h30000000, 0, 0, 0, 32'h0,        NOP,          1, 0, 32'h0,        0);
    v(1, 0, 1, 32'h30000000, 0, 0, 0, 32'h0,        NOP,          1, 1, 32'h30000000, 0);
    v(1, 0, 1, 32'h30000000, 0, 0, 0, 32'h0,        NOP,          1, 1, 32'h30000000, 0);
    v(1, 0, 1, 32'h30000000, 0, 0, 0, 32'h0,        NOP,          1, 1, 32'h30000000, 0);
    v(1, 0, 0, 32'h30000000, 0, 0, 1, 32'h34011100, 32'h34011100, 0, 1, 32'h30000000, 0);
    v(1, 0, 0, 32'h30000000, 0, 0, 0, 32'h0,        NOP,          0, 0, 32'h30000000, 0);
    // back-to-back fetches
    v(1, 0, 1, 32'h30000000, 0, 0, 0, 32'h0,        NOP,          1, 0, 32'h30000000, 0);
    v(1, 0, 1, 32'h30000004, 0, 0, 1, 32'h11111111, 32'h11111111, 0, 1, 32'h30000000, 0);
    v(1, 0, 1, 32'h30000004, 0, 0, 0, 32'h0,        NOP,          1, 0, 32'h30000000, 0);
    v(1, 0, 0, 32'h30000004, 0, 0, 1, 32'h22222222, 32'h22222222, 0, 1, 32'h30000004, 0);
    v(1, 0, 0, 32'h30000004, 0, 0, 0, 32'h0,        NOP,          0, 0, 32'h30000004, 0);
    // stall hold: ack while IF/ID held, then 4 held cycles
    v(1, 0, 1, 32'h30000008, 0, 0, 0, 32'h0,        NOP,          1, 0, 32'h30000004, 0);
    v(1, 0, 0, 32'h30000008, 1, 0, 1, 32'hDEADBEEF, 32'hDEADBEEF, 0, 1, 32'h30000008, 0);
    v(1, 0, 1, 32'h30000008, 1, 0, 1, 32'h55555555, 32'hDEADBEEF, 0, 0, 32'h30000008, 0);
    v(1, 0, 1, 32'h30000008, 1, 0, 0, 32'h0,        32'hDEADBEEF, 0, 0, 32'h30000008, 0);
    v(1, 0, 1, 32'h30000008, 1, 0, 0, 32'h0,        32'hDEADBEEF, 0, 0, 32'h30000008, 0);
    v(1, 0, 1, 32'h30000008, 1, 0, 0, 32'h0,        32'hDEADBEEF, 0, 0, 32'h30000008, 0);
    v(1, 0, 0, 32'h30000008, 0, 0, 0, 32'h0,        32'hDEADBEEF, 0, 0, 32'h30000008, 0);
    v(1, 0, 0, 32'h30000008, 0, 0, 0, 32'h0,        NOP,          0, 0, 32'h30000008, 0);
    // flush in second BUSY cycle, coincident with ack
    v(1, 0, 1, 32'h30000010, 0, 0, 0, 32'h0,        NOP,          1, 0, 32'h30000008, 0);
    v(1, 0, 0, 32'h30000010, 0, 0, 0, 32'h0,        NOP,          1, 1, 32'h30000010, 0);
    v(1, 0, 0, 32'h30000010, 0, 1, 1, 32'hCAFEF00D, NOP,          0, 1, 32'h30000010, 0);
    v(1, 0, 1, 32'h30000020, 0, 0, 0, 32'h0,        NOP,          1, 0, 32'h30000010, 0);
    v(1, 0, 0, 32'h30000020, 0, 0, 1, 32'h0BADF00D, 32'h0BADF00D, 0, 1, 32'h30000020, 0);
    // flush in IDLE blocks a new request
    v(1, 0, 1, 32'h30000024, 0, 1, 0, 32'h0,        NOP,          0, 0, 32'h30000020, 0);
    v(1, 0, 0, 32'h30000024, 0, 0, 0, 32'h0,        NOP,          0, 0, 32'h30000020, 0);
    // reset mid-read, then a late ack
    v(1, 0, 1, 32'h30000030, 0, 0, 0, 32'h0,        NOP,          1, 0, 32'h30000020, 0);
    v(1, 1, 0, 32'h30000030, 0, 0, 0, 32'h0,        NOP,          1, 1, 32'h30000030, 0);
    v(1, 0, 0, 32'h30000030, 0, 0, 1, 32'h12345678, NOP,          0, 0, 32'h0,        0);
    v(1, 0, 0, 32'h30000030, 0, 0, 0, 32'h0,        NOP,          0, 0, 32'h0,        0);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i].rst, tbl[i].ce, tbl[i].pc, tbl[i].st1, tbl[i].fl, tbl[i].ack, tbl[i].dat);
      #1;
      if (tbl[i].chk)
        check_outs(i, tbl[i].e_inst, tbl[i].e_sreq, tbl[i].e_cyc, tbl[i].e_adr, tbl[i].e_to);
    end

    check("wb_we_o", 100, {31'b0, wb_we_o}, 32'h0);
    check("wb_sel_o", 100, {28'b0, wb_sel_o}, 32'hF);

    // timeout: TIMEOUT=8, no ack ever arrives
    @(negedge clk);
    drive(1'b0, 1'b1, 32'h30000040, 1'b0, 1'b0, 1'b0, 32'h0);
    #1 check_outs(200, NOP, 1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(1'b0, 1'b0, 32'h30000040, 1'b0, 1'b0, 1'b0, 32'h0);
      #1 check_outs(201 + i, NOP, 1'b1, 1'b1, 32'h30000040, 1'b0);
    end
    @(negedge clk);
    #1 check_outs(209, NOP, 1'b0, 1'b0, 32'h30000040, 1'b1);
    @(negedge clk);
    #1 check_outs(210, NOP, 1'b0, 1'b0, 32'h30000040, 1'b0);

    // IDLE again: a fresh read completes normally after the timeout
    @(negedge clk);
    drive(1'b0, 1'b1, 32'h30000044, 1'b0, 1'b0, 1'b0, 32'h0);
    #1 check_outs(211, NOP, 1'b1, 1'b0, 32'h30000040, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h30000044, 1'b0, 1'b0, 1'b1, 32'hA5A5A5A5);
    #1 check_outs(212, 32'hA5A5A5A5, 1'b0, 1'b1, 32'h30000044, 1'b0);

    // flush releases WAIT_STALL even while IF/ID is still held
    @(negedge clk);
    drive(1'b0, 1'b1, 32'h30000048, 1'b1, 1'b0, 1'b0, 32'h0);
    #1 check_outs(213, NOP, 1'b1, 1'b0, 32'h30000044, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h30000048, 1'b1, 1'b0, 1'b1, 32'h600DF00D);
    #1 check_outs(214, 32'h600DF00D, 1'b0, 1'b1, 32'h30000048, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h30000048, 1'b1, 1'b1, 1'b0, 32'h0);
    #1 check_outs(215, 32'h600DF00D, 1'b0, 1'b0, 32'h30000048, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h30000048, 1'b1, 1'b0, 1'b0, 32'h0);
    #1 check_outs(216, NOP, 1'b0, 1'b0, 32'h30000048, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_wb_fetch_if.md
Name: inst_wb_fetch_if

Overview:
Responder side of the PC/instruction-memory interface. It accepts the fetch address `pc_i` and chip enable `ce_i` from the PC register and performs one Wishbone B4 classic read per instruction on the external instruction bus. It returns the 32-bit instruction to the IF/ID stage. While a bus read is outstanding it raises a pipeline stall request to the control module. It also honours flush and stall from the control module.

Parameters:
- `NOP_INST`, default 32'h00000000: instruction value driven on `inst_o` when no valid word is available.
- `TIMEOUT`, default 255: number of cycles BUSY may wait for `wb_ack_i` before the read is abandoned; range 1..255.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `ce_i`  in  1  instruction memory enable from PC register
- `pc_i`  in  32  fetch byte address; word aligned
- `stall`  in  6  pipeline stall vector from control; `stall[1]` = IF/ID held
- `flush`  in  1  exception flush from control
- `inst_o`  out  32  fetched instruction to IF/ID
- `stallreq_o`  out  1  stall request to control
- `timeout_o`  out  1  one-cycle pulse when a read is abandoned
- `wb_adr_o`  out  32  Wishbone address
- `wb_dat_i`  in  32  Wishbone read data
- `wb_ack_i`  in  1  Wishbone acknowledge
- `wb_cyc_o`  out  1  Wishbone cycle
- `wb_stb_o`  out  1  Wishbone strobe
- `wb_we_o`  out  1  tied 0
- `wb_sel_o`  out  4  tied 4'b1111

Behaviour:
- **States:** IDLE, BUSY, WAIT_STALL (2-bit register).
- **Reset values:** on `rst`, state = IDLE. Registered outputs `wb_cyc_o`, `wb_stb_o`, `wb_adr_o` = 0. Holding buffer = `NOP_INST`. Timeout counter = 0. `timeout_o` = 0.
- **IDLE:**
  - If `ce_i`=1 and `flush`=0: at the edge, `wb_adr_o` <= `pc_i`, `wb_cyc_o`/`wb_stb_o` <= 1, counter <= 0, go to BUSY.
  - Otherwise stay in IDLE.
- **BUSY, `flush`=1:** takes priority over everything. At the edge drop `cyc`/`stb`, discard any `ack`/data, go to IDLE.
- **BUSY, `wb_ack_i`=1 (no flush):** at the edge drop `cyc`/`stb`.
  - If `stall[1]`=1: buffer <= `wb_dat_i`, go to WAIT_STALL.
  - Otherwise go to IDLE.
- **BUSY, no ack:** counter increments. When counter == `TIMEOUT`-1 and still no ack: drop `cyc`/`stb`, pulse `timeout_o` for one cycle, buffer <= `NOP_INST`, go to IDLE.
- **WAIT_STALL:**
  - If `flush`=1: go to IDLE.
  - Else if `stall[1]`=0: go to IDLE.
  - Otherwise hold.
- **Combinational `stallreq_o`:**
  - 1 in IDLE when `ce_i`=1 and `flush`=0.
  - 1 in BUSY when `wb_ack_i`=0 and `flush`=0.
  - 0 otherwise, including WAIT_STALL.
- **Combinational `inst_o`:**
  - BUSY & `wb_ack_i` & !`flush` -> `wb_dat_i`.
  - WAIT_STALL -> buffer.
  - Otherwise `NOP_INST`.
- **Latency:** minimum 2 cycles from request (IDLE edge) to instruction, when ack arrives in the first BUSY cycle. Exactly one `ack` is consumed per read.
- **Bus rules:**
  - `cyc` and `stb` are always equal.
  - `wb_adr_o` is stable for the whole BUSY period.
  - `ack` arriving outside BUSY is ignored.
- **Reset mid-read:** `cyc`/`stb` drop at the reset edge, state returns to IDLE, no data is delivered.
- **`ce_i` falling during BUSY:** the read completes normally. The result is delivered if not flushed.

Test Plan:
- **Basic fetch.** Stimulus: reset 2 cycles; `ce_i`=1, `pc_i`=32'h30000000; memory acks 3 cycles after `stb` with 32'h34011100. Required response: `wb_adr_o`=32'h30000000; `stallreq_o`=1 until the ack cycle; `inst_o`=32'h34011100 in the ack cycle; `cyc` low on the next edge.
- **Back-to-back fetches.** Stimulus: addresses 0x30000000 then 0x30000004, each acked in the first BUSY cycle. Required response: two bus cycles 2 clocks apart; `inst_o` values match memory contents.
- **Stall hold.** Stimulus: `stall[1]`=1 during the ack of 32'hDEADBEEF, held for 4 cycles. Required response: WAIT_STALL entered; `inst_o`=32'hDEADBEEF for all 4 cycles; `stallreq_o`=0; returns to IDLE when `stall[1]`=0.
- **Flush mid-read.** Stimulus: `flush`=1 in the second BUSY cycle while the ack arrives in the same cycle. Required response: `inst_o`=`NOP_INST`; `cyc`/`stb` drop at the next edge; the next read uses the new `pc_i` (e.g. 32'h30000020).
- **Timeout.** Stimulus: `TIMEOUT`=8, no ack. Required response: `cyc` low after 8 BUSY cycles; `timeout_o` pulses exactly once; returns to IDLE.
- **Reset mid-read.** Stimulus: `rst`=1 in a BUSY cycle. Required response: all outputs at reset values on the next edge; a late ack is ignored.
